// File: rtl/apu_frame_seq_if.sv
// Register-decode <-> frame sequencer signal bundle: $4017 write, $4015 read strobe,
// and the tick / quarter / half / IRQ outputs fanned out to the channel units.
interface apu_frame_seq_if;
  logic       wr;
  logic [1:0] wdata;
  logic       rd_stat;
  logic       tick;
  logic       qframe;
  logic       hframe;
  logic       irq;
  logic       n_irq;
  logic [2:0] step;

  modport master (output wr, wdata, rd_stat,
                  input  tick, qframe, hframe, irq, n_irq, step);
  modport slave  (input  wr, wdata, rd_stat,
                  output tick, qframe, hframe, irq, n_irq, step);
endinterface

// File: rtl/apu_frame_seq.sv
// APU frame sequencer: prescaled tick, 4/5-step quarter/half-frame pulses, frame IRQ.
// Optional feature macro: APU_FRAME_IRQ_EN (frame IRQ flop; when undefined irq=0, n_irq=1).
module apu_frame_seq #(
  parameter int TICK_DIV = 2,
  parameter int CNT_W    = 15,
  parameter int Q1       = 3728,
  parameter int Q2       = 7456,
  parameter int Q3       = 11185,
  parameter int Q4       = 14914,
  parameter int Q5       = 18640
) (
  input  logic             clk,
  input  logic             n_reset,
  apu_frame_seq_if.slave   io_bus
);
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] P1 = CNT_W'(Q1);
  localparam logic [CNT_W-1:0] P2 = CNT_W'(Q2);
  localparam logic [CNT_W-1:0] P3 = CNT_W'(Q3);
  localparam logic [CNT_W-1:0] P4 = CNT_W'(Q4);
  localparam logic [CNT_W-1:0] P5 = CNT_W'(Q5);

  logic [PRE_W-1:0] r_pre;
  logic             r_tick;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mode;
  logic             r_inhibit;
  logic             r_pend;
  logic             r_q;
  logic             r_h;
  logic [2:0]       r_step;

  logic             w_q;
  logic             w_h;
  logic             w_set;
  logic             w_wrap;
  logic [2:0]       w_step;

  // Step decode; only meaningful on a normal (non-pending) tick.
  always_comb begin
    w_q    = 1'b0;
    w_h    = 1'b0;
    w_set  = 1'b0;
    w_wrap = 1'b0;
    w_step = r_step;
    if (r_tick && !r_pend) begin
      if (r_cnt == P1) begin
        w_q = 1'b1; w_step = 3'd1;
      end else if (r_cnt == P2) begin
        w_q = 1'b1; w_h = 1'b1; w_step = 3'd2;
      end else if (r_cnt == P3) begin
        w_q = 1'b1; w_step = 3'd3;
      end else if (!r_mode && r_cnt == P4) begin
        w_q = 1'b1; w_h = 1'b1; w_set = 1'b1; w_wrap = 1'b1; w_step = 3'd4;
      end else if (r_mode && r_cnt == P5) begin
        w_q = 1'b1; w_h = 1'b1; w_wrap = 1'b1; w_step = 3'd5;
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_pre     <= '0;
      r_tick    <= 1'b0;
      r_cnt     <= '0;
      r_mode    <= 1'b0;
      r_inhibit <= 1'b0;
      r_pend    <= 1'b0;
      r_q       <= 1'b0;
      r_h       <= 1'b0;
      r_step    <= 3'd0;
    end else begin
      r_pre  <= (r_pre == PRE_LAST) ? '0 : r_pre + 1'b1;
      r_tick <= (r_pre == PRE_LAST);
      r_q    <= 1'b0;
      r_h    <= 1'b0;
      if (r_tick) begin
        if (r_pend) begin
          // Deferred $4017 write: restart the sequence, 5-step mode clocks at once.
          r_cnt  <= '0;
          r_step <= 3'd0;
          r_q    <= r_mode;
          r_h    <= r_mode;
        end else begin
          r_cnt  <= w_wrap ? '0 : r_cnt + 1'b1;
          r_step <= w_step;
          r_q    <= w_q;
          r_h    <= w_h;
        end
        r_pend <= 1'b0;
      end
      // A write coincident with a tick stays pending for the following tick.
      if (io_bus.wr) begin
        r_pend               <= 1'b1;
        {r_mode, r_inhibit}  <= io_bus.wdata;
      end
    end
  end

  assign io_bus.tick   = r_tick;
  assign io_bus.qframe = r_q;
  assign io_bus.hframe = r_h;
  assign io_bus.step   = r_step;

`ifdef APU_FRAME_IRQ_EN
  logic r_irq;
  logic w_inh_now;

  // Inhibit clears the flag in the very cycle it is written, not only once stored.
  assign w_inh_now = r_inhibit | (io_bus.wr & io_bus.wdata[0]);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)                            r_irq <= 1'b0;
    else if (w_set && !w_inh_now)            r_irq <= 1'b1;
    else if (io_bus.rd_stat || w_inh_now)    r_irq <= 1'b0;
  end

  assign io_bus.irq = r_irq;
`else
  logic w_unused;
  assign w_unused   = ^{w_set, r_inhibit, io_bus.rd_stat};
  assign io_bus.irq = 1'b0;
`endif

  assign io_bus.n_irq = ~io_bus.irq;

endmodule
